uart_tx_controller: RTL and testbench

//  Control FSM that sequences the UART transmit datapath (data reg, 9-bit shift reg, bit counter).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_tick_gen.sv | 22 ++
 rtl/uart_tx_controller.sv | 81 ++++++++
 tb/tb_uart_tx_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and default sizing for the UART transmit path.
`timescale 1ns/1ps
package uart_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ARM  = 2'd2,
      SEND = 2'd3
   } tx_state_e;
   localparam int WORD_SIZE_DFLT    = 8;
   localparam int CLKS_PER_BIT_DFLT = 868;
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen: bit-period counter; ticks on the last count, held at 0 while i_run is low.
`timescale 1ns/1ps
module uart_baud_tick_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
   input  logic clk,
   input  logic rst_b,
   input  logic i_run,
   output logic o_tick
);
   localparam int            CW   = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   logic [CW-1:0] r_cnt;
   assign o_tick = i_run && (r_cnt == LAST);
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b)
         r_cnt <= '0;
      else
         r_cnt <= (!i_run || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: IDLE/LOAD/ARM/SEND sequencer driving the tx datapath strobes.
// UART_TX_BAUDGEN_EN: replaces the i_bit_tick port with an internal CLKS_PER_BIT tick generator.
`timescale 1ns/1ps
module uart_tx_controller
   import uart_pkg::*;
#(
   parameter int WORD_SIZE    = WORD_SIZE_DFLT,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
   input  logic clk,
   input  logic rst_b,
   input  logic i_wr_en,
`ifndef UART_TX_BAUDGEN_EN
   input  logic i_bit_tick,
`endif
   input  logic i_bc_lt_bcmax,
   output logic o_tx_ready,
   output logic o_tx_done,
   output logic o_load_xmt_datareg,
   output logic o_load_xmt_shiftreg,
   output logic o_start,
   output logic o_shift,
   output logic o_clear
);
   tx_state_e r_state, w_state_nxt;
   logic      w_tick;
   if (WORD_SIZE < 1 || CLKS_PER_BIT < 1) begin : g_bad_cfg
      $error("uart_tx_controller: WORD_SIZE and CLKS_PER_BIT must be positive");
   end
`ifdef UART_TX_BAUDGEN_EN
   // Counter runs only in ARM/SEND, so it restarts from 0 on every ARM entry.
   uart_baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst_b (rst_b),
      .i_run (r_state == ARM || r_state == SEND),
      .o_tick(w_tick)
   );
`else
   assign w_tick = i_bit_tick;
`endif
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   // IDLE decodes are qualified by rst_b so no strobe escapes while reset is held.
   always_comb begin
      w_state_nxt         = r_state;
      o_tx_ready          = 1'b0;
      o_tx_done           = 1'b0;
      o_load_xmt_datareg  = 1'b0;
      o_load_xmt_shiftreg = 1'b0;
      o_start             = 1'b0;
      o_shift             = 1'b0;
      o_clear             = 1'b0;
      unique case (r_state)
         IDLE: begin
            o_tx_ready         = rst_b;
            o_load_xmt_datareg = rst_b & i_wr_en;
            w_state_nxt        = i_wr_en ? LOAD : IDLE;
         end
         LOAD: begin
            o_load_xmt_shiftreg = 1'b1;
            w_state_nxt         = ARM;
         end
         ARM: begin
            o_start     = w_tick;
            w_state_nxt = w_tick ? SEND : ARM;
         end
         SEND: begin
            o_shift     = w_tick & i_bc_lt_bcmax;
            o_clear     = w_tick & ~i_bc_lt_bcmax;
            o_tx_done   = w_tick & ~i_bc_lt_bcmax;
            w_state_nxt = (w_tick && !i_bc_lt_bcmax) ? IDLE : SEND;
         end
         default: w_state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: directed bench pairing the controller with a behavioural tx datapath.
`timescale 1ns/1ps
module tb_uart_tx_controller;
   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic       wr_en = 1'b1;
   logic       bit_tick = 1'b1;
   logic [7:0] data_bus = 8'h00;
   logic       tx_ready, tx_done, ld_dr, ld_sr, start, shift, clear;
   logic [3:0] m_bc;
   logic [7:0] m_dr;
   logic       bc_lt;
   int checks = 0, failures = 0, cyc = 0;
   int n_dr, n_sr, n_st, n_sh, n_cl, n_dn, n_multi, n_busy;
   int c_dr, c_sr, c_st, c_sh, c_cl, c_dn;

   always #5 clk = ~clk;
   assign bc_lt = m_bc < 4'd9;

`ifdef UART_TX_BAUDGEN_EN
   uart_tx_controller #(.WORD_SIZE(8), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .rst_b(rst_b), .i_wr_en(wr_en), .i_bc_lt_bcmax(bc_lt),
      .o_tx_ready(tx_ready), .o_tx_done(tx_done), .o_load_xmt_datareg(ld_dr),
      .o_load_xmt_shiftreg(ld_sr), .o_start(start), .o_shift(shift), .o_clear(clear));
`else
   uart_tx_controller #(.WORD_SIZE(8), .CLKS_PER_BIT(16)) dut (
      .clk(clk), .rst_b(rst_b), .i_wr_en(wr_en), .i_bit_tick(bit_tick), .i_bc_lt_bcmax(bc_lt),
      .o_tx_ready(tx_ready), .o_tx_done(tx_done), .o_load_xmt_datareg(ld_dr),
      .o_load_xmt_shiftreg(ld_sr), .o_start(start), .o_shift(shift), .o_clear(clear));
`endif

   // Behavioural datapath: data register and bit counter, reset with the controller.
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         m_bc <= 4'd0;
         m_dr <= 8'h00;
      end else begin
         if (clear) m_bc <= 4'd0;
         else if (shift) m_bc <= m_bc + 4'd1;
         if (ld_dr) m_dr <= data_bus;
      end

   task automatic clr_counts();
      {n_dr, n_sr, n_st, n_sh, n_cl, n_dn, n_multi, n_busy} = '0;
      {c_dr, c_sr, c_st, c_sh, c_cl, c_dn} = {6{-32'sd1}};
      cyc = 0;
   endtask

   task automatic step(input logic wr, input logic tk);
      @(negedge clk);
      wr_en = wr;
      bit_tick = tk;
      #2;
      if (tx_ready && cyc > 0 && n_dn == 0) n_busy++;
      if ($countones({ld_dr, ld_sr, start, shift, clear}) > 1) n_multi++;
      if (ld_dr) begin n_dr++; c_dr = cyc; end
      if (ld_sr) begin n_sr++; c_sr = cyc; end
      if (start) begin n_st++; c_st = cyc; end
      if (shift) begin n_sh++; c_sh = cyc; end
      if (clear) begin n_cl++; c_cl = cyc; end
      if (tx_done) begin n_dn++; c_dn = cyc; end
      cyc++;
   endtask

   task automatic frame(input logic [7:0] d, input int first, input int period,
                        input logic hold, input logic [7:0] d2);
      clr_counts();
      data_bus = d;
      step(1'b1, 1'b0);
      @(posedge clk);
      #1 data_bus = d2;
      for (int k = 0; k < 600 && n_dn == 0; k++)
         step(hold, cyc >= first && (cyc - first) % period == 0);
      checks++;
      if (n_dn == 0) begin failures++; $display("FAIL frame_timeout: tx_done count %0d required 1", n_dn); end
   endtask

   task automatic test_reset();
      int bad = 0;
      repeat (4) begin
         @(negedge clk);
         #2 if (ld_dr | ld_sr | start | shift | clear | tx_done) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL reset_strobes: %0d active cycles, required 0", bad); end
      @(negedge clk);
      rst_b = 1'b1;
      wr_en = 1'b0;
      bit_tick = 1'b0;
      #2;
      checks++;
      if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", tx_ready); end
      checks++;
      if ({ld_dr, ld_sr, start, shift, clear, tx_done} !== 6'b0) begin
         failures++; $display("FAIL reset_idle_strobes: got %b required 000000", {ld_dr, ld_sr, start, shift, clear, tx_done});
      end
   endtask

   task automatic test_single_frame();
      frame(8'hA5, 15, 16, 1'b0, 8'h5A);
      checks++; if (c_dr !== 0)   begin failures++; $display("FAIL single_dr_cycle: got %0d required 0", c_dr); end
      checks++; if (c_sr !== 1)   begin failures++; $display("FAIL single_sr_cycle: got %0d required 1", c_sr); end
      checks++; if (n_st !== 1 || c_st !== 15) begin failures++; $display("FAIL single_start: n=%0d c=%0d required 1/15", n_st, c_st); end
      checks++; if (n_sh !== 9)   begin failures++; $display("FAIL single_shifts: got %0d required 9", n_sh); end
      checks++; if (n_cl !== 1 || c_cl !== 175) begin failures++; $display("FAIL single_clear: n=%0d c=%0d required 1/175", n_cl, c_cl); end
      checks++; if (n_dn !== 1 || c_dn !== 175) begin failures++; $display("FAIL single_done: n=%0d c=%0d required 1/175", n_dn, c_dn); end
      checks++; if (n_multi !== 0 || n_busy !== 0) begin failures++; $display("FAIL single_exclusive: multi=%0d busy_ready=%0d required 0/0", n_multi, n_busy); end
      checks++; if (m_dr !== 8'hA5) begin failures++; $display("FAIL single_datareg: got %h required a5", m_dr); end
      step(1'b0, 1'b0);
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL single_ready_after: got %b required 1", tx_ready); end
      checks++; if (m_bc !== 4'd0) begin failures++; $display("FAIL single_bitcount: got %0d required 0", m_bc); end
   endtask

   task automatic test_back_to_back();
      frame(8'h3C, 15, 16, 1'b1, 8'hC3);
      checks++; if (n_dr !== 1) begin failures++; $display("FAIL b2b_extra_dr: got %0d required 1", n_dr); end
      checks++; if (m_dr !== 8'h3C) begin failures++; $display("FAIL b2b_datareg_held: got %h required 3c", m_dr); end
      checks++; if (n_sh !== 9 || c_cl !== 175) begin failures++; $display("FAIL b2b_frame: shifts=%0d clear=%0d required 9/175", n_sh, c_cl); end
      step(1'b1, 1'b0);
      checks++; if (n_dr !== 2 || c_dr !== 176) begin failures++; $display("FAIL b2b_accept: n=%0d c=%0d required 2/176", n_dr, c_dr); end
      step(1'b0, 1'b0);
      checks++; if (m_dr !== 8'hC3) begin failures++; $display("FAIL b2b_second_byte: got %h required c3", m_dr); end
      clr_counts();
      for (int k = 0; k < 100 && n_dn == 0; k++) step(1'b0, 1'b1);
      checks++; if (n_sh !== 9 || n_dn !== 1) begin failures++; $display("FAIL b2b_drain: shifts=%0d done=%0d required 9/1", n_sh, n_dn); end
   endtask

   task automatic test_tick_in_load();
      frame(8'h81, 1, 16, 1'b0, 8'h00);
      checks++; if (c_sr !== 1) begin failures++; $display("FAIL load_tick_sr: got %0d required 1", c_sr); end
      checks++; if (n_st !== 1 || c_st !== 17) begin failures++; $display("FAIL load_tick_start: n=%0d c=%0d required 1/17", n_st, c_st); end
      checks++; if (n_sh !== 9 || c_cl !== 177) begin failures++; $display("FAIL load_tick_frame: shifts=%0d clear=%0d required 9/177", n_sh, c_cl); end
   endtask

   task automatic test_mid_frame_reset();
      clr_counts();
      data_bus = 8'h5A;
      step(1'b1, 1'b0);
      for (int k = 0; k < 400 && n_sh < 4; k++)
         step(1'b0, cyc >= 3 && (cyc - 3) % 4 == 0);
      checks++; if (n_sh !== 4 || c_sh !== 19) begin failures++; $display("FAIL abort_progress: shifts=%0d c=%0d required 4/19", n_sh, c_sh); end
      wr_en = 1'b1;
      bit_tick = 1'b1;
      #1 rst_b = 1'b0;
      #1;
      checks++;
      if ({ld_dr, ld_sr, start, shift, clear, tx_done} !== 6'b0) begin
         failures++; $display("FAIL abort_strobes: got %b required 000000", {ld_dr, ld_sr, start, shift, clear, tx_done});
      end
      checks++; if (m_bc !== 4'd0) begin failures++; $display("FAIL abort_bitcount: got %0d required 0", m_bc); end
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      wr_en = 1'b0;
      bit_tick = 1'b0;
      frame(8'h96, 15, 16, 1'b0, 8'h00);
      checks++; if (c_dr !== 0 || c_st !== 15) begin failures++; $display("FAIL abort_restart: dr=%0d start=%0d required 0/15", c_dr, c_st); end
      checks++; if (n_sh !== 9 || n_cl !== 1 || c_cl !== 175) begin failures++; $display("FAIL abort_full_frame: shifts=%0d clears=%0d c=%0d required 9/1/175", n_sh, n_cl, c_cl); end
      checks++; if (m_dr !== 8'h96) begin failures++; $display("FAIL abort_datareg: got %h required 96", m_dr); end
   endtask

   task automatic test_baudgen();
      frame(8'h42, 100000, 1, 1'b0, 8'h00);
      checks++; if (n_st !== 1 || c_st !== 5) begin failures++; $display("FAIL baud_start: n=%0d c=%0d required 1/5", n_st, c_st); end
      checks++; if (n_sh !== 9 || c_sh !== 41) begin failures++; $display("FAIL baud_shifts: n=%0d last=%0d required 9/41", n_sh, c_sh); end
      checks++; if (c_cl !== 45 || c_dn !== 45) begin failures++; $display("FAIL baud_end: clear=%0d done=%0d required 45/45", c_cl, c_dn); end
   endtask

   initial begin
      clr_counts();
      test_reset();
`ifdef UART_TX_BAUDGEN_EN
      test_baudgen();
`else
      test_single_frame();
      test_back_to_back();
      test_tick_in_load();
      test_mid_frame_reset();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
